// File: rtl/wimax_rx_pkg.sv
// WiMAX receive-side shared definitions: block geometry defaults,
// derived widths and the reference deinterleaver index function.
package wimax_rx_pkg;

   localparam int NCBPS_DEF = 192;
   localparam int D_DEF     = 16;
   localparam int NCPC_DEF  = 2;
   localparam int COLS_DEF  = NCBPS_DEF / D_DEF;
   localparam int AW_DEF    = $clog2(NCBPS_DEF);

   // Position k in FEC order of the j-th received bit (QPSK, s=1).
   function automatic int deint_index(
      input int j,
      input int ncbps = NCBPS_DEF,
      input int d     = D_DEF
   );
      return d * j - (ncbps - 1) * ((d * j) / ncbps);
   endfunction

endpackage

// File: rtl/wimax_deint_addr_gen.sv
// Incremental write-address generator for the deinterleaver.
// Ports: clk_ref, rst, advance (bit accepted), clear (block start), k (address).
module wimax_deint_addr_gen
   import wimax_rx_pkg::*;
#(
   parameter int NCBPS = NCBPS_DEF,
   parameter int D     = D_DEF,
   localparam int AW   = $clog2(NCBPS)
) (
   input  logic          clk_ref,
   input  logic          rst,
   input  logic          advance,
   input  logic          clear,
   output logic [AW-1:0] k
);

   localparam int COLS = NCBPS / D;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW   = (D > 1) ? $clog2(D) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [AW-1:0] K_STEP   = AW'(D);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [AW-1:0] r_k;

   // Walking a row adds D; wrapping to the next row restarts at row+1.
   always_ff @(posedge clk_ref) begin
      if (rst || clear) begin
         r_col <= '0;
         r_row <= '0;
         r_k   <= '0;
      end else if (advance) begin
         if (r_col == COL_LAST) begin
            r_k   <= AW'(r_row) + AW'(1);
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_k   <= r_k + K_STEP;
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign k = r_k;

endmodule

// File: rtl/wimax_deinterleaver.sv
// Ping-pong block deinterleaver: serial bits in, FEC-order bits out.
// Ports: clk_ref, rst, valid_in/data_in/ready_in (in), valid_out/data_out/data_last/ready_out (out).
module wimax_deinterleaver
   import wimax_rx_pkg::*;
#(
   parameter int NCBPS = NCBPS_DEF,
   parameter int D     = D_DEF,
   parameter int NCPC  = NCPC_DEF
) (
   input  logic clk_ref,
   input  logic rst,
   input  logic valid_in,
   input  logic data_in,
   output logic ready_in,
   output logic valid_out,
   output logic data_out,
   output logic data_last,
   input  logic ready_out
);

   localparam int AW = $clog2(NCBPS);
   localparam logic [AW-1:0] LAST = AW'(NCBPS - 1);

   generate
      if (NCPC != 2) begin : g_bad_ncpc
         $error("wimax_deinterleaver: only NCPC=2 is supported");
      end
      if ((NCBPS % D) != 0) begin : g_bad_d
         $error("wimax_deinterleaver: NCBPS must be divisible by D");
      end
   endgenerate

   logic [NCBPS-1:0] r_bank [2];
   logic [1:0]       r_full;
   logic             r_wr_bank;
   logic             r_rd_bank;
   logic [AW-1:0]    r_rd_cnt;

   logic [AW-1:0]    w_wr_addr;
   logic             w_wr_fire;
   logic             w_wr_done;
   logic             w_rd_fire;
   logic             w_rd_done;
   logic [1:0]       w_full_nxt;

   assign ready_in  = !r_full[r_wr_bank];
   assign valid_out = r_full[r_rd_bank];
   assign data_out  = valid_out & r_bank[r_rd_bank][r_rd_cnt];
   assign data_last = valid_out && (r_rd_cnt == LAST);

   assign w_wr_fire = valid_in && ready_in;
   assign w_rd_fire = valid_out && ready_out;
   assign w_rd_done = w_rd_fire && (r_rd_cnt == LAST);

   // The permutation maps j=NCBPS-1 to k=NCBPS-1 and nothing else
   // there, so the address alone marks the final bit of a block.
   assign w_wr_done = w_wr_fire && (w_wr_addr == LAST);

   wimax_deint_addr_gen #(
      .NCBPS (NCBPS),
      .D     (D)
   ) u_addr_gen (
      .clk_ref (clk_ref),
      .rst     (rst),
      .advance (w_wr_fire),
      .clear   (w_wr_done),
      .k       (w_wr_addr)
   );

   // Writer only fills a non-full bank and reader only frees a full
   // one, so a same-cycle set and clear always hit different flags.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
      if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
   end

   always_ff @(posedge clk_ref) begin
      if (rst) begin
         r_full    <= '0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= '0;
      end else begin
         r_full <= w_full_nxt;
         if (w_wr_done) r_wr_bank <= !r_wr_bank;
         if (w_rd_fire) begin
            if (w_rd_done) begin
               r_rd_cnt  <= '0;
               r_rd_bank <= !r_rd_bank;
            end else begin
               r_rd_cnt  <= r_rd_cnt + 1'b1;
            end
         end
      end
   end

   // Bank storage carries no reset; contents are qualified by r_full.
   always_ff @(posedge clk_ref) begin
      if (w_wr_fire) r_bank[r_wr_bank][w_wr_addr] <= data_in;
   end

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Self-checking bench for wimax_deinterleaver: block-level model,
// per-cycle compare, directed golden/spot/backpressure/reset tests.
module tb_wimax_deinterleaver;
   import wimax_rx_pkg::*;

   localparam int N  = 192;
   localparam int DD = 16;

   localparam logic [N-1:0] GOLD_IN  =
      192'h4b047dfa42f2a5d5f61c021a5851e9a309a24fd58086bd1e;
   localparam logic [N-1:0] GOLD_OUT =
      192'h2833e48d392026d5b6dc5e4af47add29494b6c89151348ca;

   logic clk_ref = 1'b0;
   logic rst = 1'b1;
   logic valid_in = 1'b0;
   logic data_in = 1'b0;
   logic ready_out = 1'b0;
   logic ready_in;
   logic valid_out;
   logic data_out;
   logic data_last;

   always #5 clk_ref = ~clk_ref;

   wimax_deinterleaver dut (
      .clk_ref   (clk_ref),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .data_last (data_last),
      .ready_out (ready_out)
   );

   int checks = 0;
   int errors = 0;

   bit           src_q [$];
   logic [N-1:0] exp_q [$];
   logic [N-1:0] cur_in = '0;
   logic [N-1:0] cap = '0;
   logic [N-1:0] last_blk = '0;
   int           wr_j = 0;
   int           rd_k = 0;
   int           acc_cnt = 0;

   // Vectors are MSB-first: bit index i of the stream is v[N-1-i].
   function automatic logic [N-1:0] model_block(input logic [N-1:0] inb);
      logic [N-1:0] o;
      o = '0;
      for (int j = 0; j < N; j++)
         o[N-1-deint_index(j, N, DD)] = inb[N-1-j];
      return o;
   endfunction

   task automatic chk(input string nm, input logic [N-1:0] a,
                      input logic [N-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic cyc(input bit v_en, input bit r_en);
      @(negedge clk_ref);
      valid_in  = v_en && (src_q.size() > 0);
      data_in   = valid_in ? src_q[0] : 1'b0;
      ready_out = r_en;
      #1;
      chk("valid_out", N'(valid_out), N'(exp_q.size() > 0));
      chk("ready_in", N'(ready_in), N'(exp_q.size() < 2));
      if (valid_out && exp_q.size() > 0) begin
         chk("data_out", N'(data_out), N'(exp_q[0][N-1-rd_k]));
         chk("data_last", N'(data_last), N'(rd_k == N-1));
      end else if (!valid_out) begin
         chk("idle_data", N'(data_out), '0);
         chk("idle_last", N'(data_last), '0);
      end
      if (valid_out && ready_out && exp_q.size() > 0) begin
         cap[N-1-rd_k] = data_out;
         rd_k++;
         if (rd_k == N) begin
            last_blk = cap;
            void'(exp_q.pop_front());
            rd_k = 0;
         end
      end
      if (valid_in && ready_in) begin
         cur_in[N-1-wr_j] = data_in;
         wr_j++;
         acc_cnt++;
         void'(src_q.pop_front());
         if (wr_j == N) begin
            exp_q.push_back(model_block(cur_in));
            wr_j = 0;
         end
      end
   endtask

   task automatic push_block(input logic [N-1:0] v);
      for (int j = 0; j < N; j++) src_q.push_back(v[N-1-j]);
   endtask

   function automatic logic [N-1:0] rand_block();
      logic [N-1:0] v;
      for (int j = 0; j < N; j++) v[j] = 1'($urandom_range(1));
      return v;
   endfunction

   task automatic run_n(input int n, input int pv, input int pr);
      for (int i = 0; i < n; i++)
         cyc($urandom_range(99) < pv, $urandom_range(99) < pr);
   endtask

   task automatic drain(input string nm, input int pv, input int pr,
                        input int maxc, output int used);
      used = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && used < maxc) begin
         cyc($urandom_range(99) < pv, $urandom_range(99) < pr);
         used++;
      end
      checks++;
      if (src_q.size() > 0 || exp_q.size() > 0) begin
         errors++;
         $display("FAIL %s timeout src=%0d blocks=%0d", nm,
                  src_q.size(), exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(negedge clk_ref);
      rst = 1'b1;
      valid_in = 1'b0;
      data_in = 1'b0;
      ready_out = 1'b0;
      repeat (2) @(negedge clk_ref);
      rst = 1'b0;
      src_q.delete();
      exp_q.delete();
      wr_j = 0;
      rd_k = 0;
      #1;
      chk("rst_ready_in", N'(ready_in), N'(1));
      chk("rst_valid_out", N'(valid_out), '0);
      chk("rst_data_out", N'(data_out), '0);
      chk("rst_data_last", N'(data_last), '0);
   endtask

   initial begin
      int used;
      int a0;
      int spot_j [3];
      int spot_k [3];
      logic [N-1:0] one;
      logic [N-1:0] b3;

      spot_j = '{12, 1, 191};
      spot_k = '{1, 16, 191};
      one = 1;

      do_reset();

      chk("idx0", N'(deint_index(0, N, DD)), N'(0));
      chk("idx12", N'(deint_index(12, N, DD)), N'(1));
      chk("idx1", N'(deint_index(1, N, DD)), N'(16));
      chk("idx191", N'(deint_index(191, N, DD)), N'(191));
      chk("model_gold", model_block(GOLD_IN), GOLD_OUT);

      push_block(GOLD_IN);
      drain("golden", 100, 100, 1000, used);
      chk("golden_out", last_blk, GOLD_OUT);
      chk("golden_cycles", N'(used), N'(384));

      for (int s = 0; s < 3; s++) begin
         push_block(one << (N-1-spot_j[s]));
         drain("spot", 100, 100, 1000, used);
         chk("spot_out", last_blk, one << (N-1-spot_k[s]));
      end

      push_block(GOLD_IN);
      push_block(GOLD_IN);
      drain("back2back", 100, 100, 2000, used);
      chk("b2b_cycles", N'(used), N'(576));
      chk("b2b_out", last_blk, GOLD_OUT);

      a0 = acc_cnt;
      push_block(rand_block());
      push_block(rand_block());
      b3 = rand_block();
      push_block(b3);
      run_n(450, 100, 0);
      chk("bp_accepts", N'(acc_cnt - a0), N'(384));
      chk("bp_ready_low", N'(ready_in), '0);
      drain("backpressure", 100, 100, 2000, used);
      chk("bp_third", last_blk, model_block(b3));
      chk("bp_total", N'(acc_cnt - a0), N'(576));

      for (int b = 0; b < 20; b++) push_block(rand_block());
      drain("random", 50, 50, 40000, used);

      push_block(GOLD_IN);
      a0 = acc_cnt;
      for (int i = 0; i < 400 && acc_cnt - a0 < 100; i++) cyc(1'b1, 1'b1);
      chk("mid_accepts", N'(acc_cnt - a0), N'(100));
      do_reset();
      run_n(300, 0, 100);
      push_block(GOLD_IN);
      drain("after_reset", 100, 100, 1000, used);
      chk("after_reset_out", last_blk, GOLD_OUT);
      chk("after_reset_cycles", N'(used), N'(384));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
